// File: rtl/sign_mag_accumulator.sv
// rtl/sign_mag_accumulator.sv - edge-triggered sign-magnitude accumulator with saturation and 7-segment output
module sign_mag_accumulator #(
    parameter int MAG_BITS = 3,
    parameter int ACC_BITS = 7,
    parameter int CNT_BITS = 4
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic                operand_sign,
    input  logic [MAG_BITS-1:0] operand_mag,
    input  logic                op,
    input  logic                enter,
    input  logic                clear,
    output logic                acc_sign,
    output logic [ACC_BITS-1:0] acc_mag,
    output logic                overflow,
    output logic                busy,
    output logic                result_valid,
    output logic [CNT_BITS-1:0] op_count,
    output logic [7:0]          seg
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [ACC_BITS-1:0] MAG_MAX = '1;

    state_t              state_q, state_d;
    logic                enter_q, enter_d;
    logic                opnd_sign_q, opnd_sign_d;
    logic [ACC_BITS-1:0] opnd_mag_q, opnd_mag_d;
    logic                acc_sign_q, acc_sign_d;
    logic [ACC_BITS-1:0] acc_mag_q, acc_mag_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;
    logic                result_valid_q, result_valid_d;
    logic [CNT_BITS-1:0] op_count_q, op_count_d;

    logic                enter_edge;
    logic [ACC_BITS:0]   sum_w;
    logic                res_sign;
    logic [ACC_BITS-1:0] res_mag;
    logic                res_ovf;
    logic [6:0]          seg_digit;

    assign enter_edge = enter & ~enter_q;
    assign sum_w      = {1'b0, acc_mag_q} + {1'b0, opnd_mag_q};

    // Opposite signs with equal magnitudes fall through to +0 so -0 never appears.
    always_comb begin
        res_sign = 1'b0;
        res_mag  = '0;
        res_ovf  = 1'b0;
        if (opnd_sign_q == acc_sign_q) begin
            res_sign = acc_sign_q;
            if (sum_w[ACC_BITS]) begin
                res_mag = MAG_MAX;
                res_ovf = 1'b1;
            end else begin
                res_mag = sum_w[ACC_BITS-1:0];
            end
        end else if (acc_mag_q > opnd_mag_q) begin
            res_sign = acc_sign_q;
            res_mag  = acc_mag_q - opnd_mag_q;
        end else if (acc_mag_q < opnd_mag_q) begin
            res_sign = opnd_sign_q;
            res_mag  = opnd_mag_q - acc_mag_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        enter_d        = enter;
        opnd_sign_d    = opnd_sign_q;
        opnd_mag_d     = opnd_mag_q;
        acc_sign_d     = acc_sign_q;
        acc_mag_d      = acc_mag_q;
        overflow_d     = overflow_q;
        busy_d         = busy_q;
        result_valid_d = result_valid_q;
        op_count_d     = op_count_q;
        if (clear) begin
            state_d        = S_IDLE;
            acc_sign_d     = 1'b0;
            acc_mag_d      = '0;
            overflow_d     = 1'b0;
            busy_d         = 1'b0;
            result_valid_d = 1'b0;
            op_count_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    if (enter_edge) begin
                        opnd_sign_d = operand_sign ^ op;
                        opnd_mag_d  = {{(ACC_BITS-MAG_BITS){1'b0}}, operand_mag};
                        busy_d      = 1'b1;
                        state_d     = S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_sign_d     = res_sign;
                    acc_mag_d      = res_mag;
                    overflow_d     = overflow_q | res_ovf;
                    result_valid_d = 1'b1;
                    op_count_d     = op_count_q + CNT_BITS'(1);
                    state_d        = S_DONE;
                end
                S_DONE: begin
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    state_d        = S_IDLE;
                end
                default: begin
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    state_d        = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q        <= S_IDLE;
            enter_q        <= 1'b0;
            opnd_sign_q    <= 1'b0;
            opnd_mag_q     <= '0;
            acc_sign_q     <= 1'b0;
            acc_mag_q      <= '0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            enter_q        <= enter_d;
            opnd_sign_q    <= opnd_sign_d;
            opnd_mag_q     <= opnd_mag_d;
            acc_sign_q     <= acc_sign_d;
            acc_mag_q      <= acc_mag_d;
            overflow_q     <= overflow_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            op_count_q     <= op_count_d;
        end
    end

    always_comb begin
        case (acc_mag_q[3:0])
            4'h0: seg_digit = 7'h3F;
            4'h1: seg_digit = 7'h06;
            4'h2: seg_digit = 7'h5B;
            4'h3: seg_digit = 7'h4F;
            4'h4: seg_digit = 7'h66;
            4'h5: seg_digit = 7'h6D;
            4'h6: seg_digit = 7'h7D;
            4'h7: seg_digit = 7'h07;
            4'h8: seg_digit = 7'h7F;
            4'h9: seg_digit = 7'h6F;
            4'hA: seg_digit = 7'h77;
            4'hB: seg_digit = 7'h7C;
            4'hC: seg_digit = 7'h39;
            4'hD: seg_digit = 7'h5E;
            4'hE: seg_digit = 7'h79;
            default: seg_digit = 7'h71;
        endcase
    end

    assign acc_sign     = acc_sign_q;
    assign acc_mag      = acc_mag_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign op_count     = op_count_q;
    assign seg          = {acc_sign_q, seg_digit};

endmodule

// File: tb/tb_sign_mag_accumulator.sv
// tb/tb_sign_mag_accumulator.sv - randomized self-checking bench for sign_mag_accumulator
module tb_sign_mag_accumulator;

    localparam int MB  = 3;
    localparam int AB  = 4;
    localparam int CB  = 2;
    localparam int MAX = (1 << AB) - 1;

    logic          clk_2 = 1'b0;
    logic          reset = 1'b0;
    logic          operand_sign = 1'b0;
    logic [MB-1:0] operand_mag = '0;
    logic          op = 1'b0;
    logic          enter = 1'b0;
    logic          clear = 1'b0;
    logic          acc_sign;
    logic [AB-1:0] acc_mag;
    logic          overflow;
    logic          busy;
    logic          result_valid;
    logic [CB-1:0] op_count;
    logic [7:0]    seg;

    int checks = 0;
    int failures = 0;

    int m_acc = 0;
    bit m_ovf = 1'b0;
    int m_cnt = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sign_mag_accumulator #(.MAG_BITS(MB), .ACC_BITS(AB), .CNT_BITS(CB)) dut (
        .clk_2(clk_2), .reset(reset), .operand_sign(operand_sign), .operand_mag(operand_mag),
        .op(op), .enter(enter), .clear(clear), .acc_sign(acc_sign), .acc_mag(acc_mag),
        .overflow(overflow), .busy(busy), .result_valid(result_valid), .op_count(op_count),
        .seg(seg)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // Signed-integer reference: add the effective operand, clamp to +/-MAX.
    task automatic model_apply(input bit s, input int mag, input bit o);
        int r;
        r = m_acc + (((s ^ o) != 1'b0) ? -mag : mag);
        if (r > MAX) begin
            r = MAX;
            m_ovf = 1'b1;
        end else if (r < -MAX) begin
            r = -MAX;
            m_ovf = 1'b1;
        end
        m_acc = r;
        m_cnt = (m_cnt + 1) % (1 << CB);
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic do_op(input bit s, input int mag, input bit o);
        bit         es;
        int         em;
        logic [7:0] eseg;
        operand_sign = s;
        operand_mag  = MB'(mag);
        op           = o;
        enter        = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL op_accept: busy=%b rv=%b expected busy=1 rv=0", busy, result_valid);
        end
        enter = 1'b0;
        tick();
        model_apply(s, mag, o);
        es   = (m_acc < 0);
        em   = es ? -m_acc : m_acc;
        eseg = {es, seg_tab[em % 16]};
        checks++;
        if (result_valid !== 1'b1) begin
            failures++;
            $display("FAIL op_result_valid: got %b expected 1", result_valid);
        end
        checks++;
        if (acc_sign !== es || acc_mag !== AB'(em)) begin
            failures++;
            $display("FAIL op_acc: got sign=%b mag=%0d expected sign=%b mag=%0d", acc_sign, acc_mag, es, em);
        end
        checks++;
        if (overflow !== m_ovf || op_count !== CB'(m_cnt) || seg !== eseg) begin
            failures++;
            $display("FAIL op_flags: got ovf=%b cnt=%0d seg=%h expected ovf=%b cnt=%0d seg=%h",
                     overflow, op_count, seg, m_ovf, m_cnt, eseg);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL op_done: rv=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        checks++;
        if (acc_sign !== 1'b0 || acc_mag !== '0 || overflow !== 1'b0 || op_count !== '0 ||
            busy !== 1'b0 || result_valid !== 1'b0 || seg !== 8'h3F) begin
            failures++;
            $display("FAIL reset: sign=%b mag=%0d ovf=%b cnt=%0d busy=%b rv=%b seg=%h expected all 0, seg=3f",
                     acc_sign, acc_mag, overflow, op_count, busy, result_valid, seg);
        end
    endtask

    task automatic test_basic();
        do_op(1'b0, 3, 1'b0);
        do_op(1'b0, 5, 1'b0);
        checks++;
        if (acc_mag !== 4'd8 || acc_sign !== 1'b0 || seg !== 8'h7F || op_count !== 2'd2) begin
            failures++;
            $display("FAIL basic_sum: mag=%0d sign=%b seg=%h cnt=%0d expected 8 0 7f 2", acc_mag, acc_sign, seg, op_count);
        end
    endtask

    task automatic test_signs();
        do_clear();
        do_op(1'b0, 2, 1'b0);
        do_op(1'b0, 6, 1'b1);
        checks++;
        if (acc_sign !== 1'b1 || acc_mag !== 4'd4 || seg !== 8'hE6) begin
            failures++;
            $display("FAIL signs_neg: sign=%b mag=%0d seg=%h expected 1 4 e6", acc_sign, acc_mag, seg);
        end
        do_op(1'b1, 4, 1'b1);
        checks++;
        if (acc_sign !== 1'b0 || acc_mag !== 4'd0 || seg !== 8'h3F) begin
            failures++;
            $display("FAIL signs_zero: sign=%b mag=%0d seg=%h expected 0 0 3f", acc_sign, acc_mag, seg);
        end
        do_op(1'b1, 0, 1'b0);
        checks++;
        if (acc_sign !== 1'b0 || acc_mag !== 4'd0) begin
            failures++;
            $display("FAIL signs_neg_zero: sign=%b mag=%0d expected 0 0", acc_sign, acc_mag);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        do_op(1'b0, 7, 1'b0);
        do_op(1'b0, 7, 1'b0);
        do_op(1'b0, 7, 1'b0);
        checks++;
        if (acc_mag !== 4'd15 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL saturate: mag=%0d ovf=%b expected 15 1", acc_mag, overflow);
        end
        do_op(1'b0, 7, 1'b1);
        checks++;
        if (acc_mag !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL saturate_sticky: mag=%0d ovf=%b expected 8 1", acc_mag, overflow);
        end
    endtask

    task automatic test_hold();
        int c0;
        c0 = m_cnt;
        operand_sign = 1'b0;
        operand_mag  = MB'(1);
        op           = 1'b0;
        enter        = 1'b1;
        repeat (10) tick();
        enter = 1'b0;
        model_apply(1'b0, 1, 1'b0);
        checks++;
        if (op_count !== CB'((c0 + 1) % (1 << CB)) || acc_mag !== AB'(m_acc)) begin
            failures++;
            $display("FAIL hold_one_op: cnt=%0d mag=%0d expected %0d %0d", op_count, acc_mag, (c0 + 1) % (1 << CB), m_acc);
        end
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        enter = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_busy: busy=%b expected 1", busy);
        end
        repeat (5) tick();
        enter = 1'b0;
        model_apply(1'b0, 1, 1'b0);
        checks++;
        if (op_count !== CB'(m_cnt) || busy !== 1'b0 || acc_mag !== AB'(m_acc)) begin
            failures++;
            $display("FAIL busy_edge_dropped: cnt=%0d busy=%b mag=%0d expected %0d 0 %0d", op_count, busy, acc_mag, m_cnt, m_acc);
        end
        tick();
    endtask

    task automatic test_clear_exec();
        do_clear();
        do_op(1'b0, 3, 1'b0);
        operand_sign = 1'b0;
        operand_mag  = MB'(5);
        op           = 1'b0;
        enter        = 1'b1;
        tick();
        enter = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        checks++;
        if (acc_mag !== '0 || acc_sign !== 1'b0 || op_count !== '0 || overflow !== 1'b0 ||
            result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_exec: mag=%0d sign=%b cnt=%0d ovf=%b rv=%b busy=%b expected all 0",
                     acc_mag, acc_sign, op_count, overflow, result_valid, busy);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || acc_mag !== '0) begin
            failures++;
            $display("FAIL clear_exec_after: rv=%b mag=%0d expected 0 0", result_valid, acc_mag);
        end
        enter = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        enter = 1'b0;
        checks++;
        if (op_count !== '0 || busy !== 1'b0 || acc_mag !== '0) begin
            failures++;
            $display("FAIL clear_edge_dropped: cnt=%0d busy=%b mag=%0d expected 0 0 0", op_count, busy, acc_mag);
        end
        tick();
    endtask

    task automatic test_wrap();
        int exp_seq [5] = '{1, 2, 3, 0, 1};
        do_clear();
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, 1, 1'b0);
            checks++;
            if (op_count !== CB'(exp_seq[i])) begin
                failures++;
                $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, op_count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 11) == 0) do_clear();
            do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_done();
        do_op(1'b0, 6, 1'b0);
        operand_sign = 1'b0;
        operand_mag  = MB'(3);
        op           = 1'b0;
        enter        = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        checks++;
        if (acc_sign !== 1'b0 || acc_mag !== '0 || overflow !== 1'b0 || op_count !== '0 ||
            busy !== 1'b0 || result_valid !== 1'b0 || seg !== 8'h3F) begin
            failures++;
            $display("FAIL reset_mid_done: sign=%b mag=%0d ovf=%b cnt=%0d busy=%b rv=%b seg=%h expected all 0, seg=3f",
                     acc_sign, acc_mag, overflow, op_count, busy, result_valid, seg);
        end
        do_op(1'b1, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_saturate();
        test_hold();
        test_clear_exec();
        test_wrap();
        test_random();
        test_reset_mid_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
